rx_decrypt: RTL
===============

RX_DECRYPT -- requirements
Module: rx_decrypt

Interface
REQ-001 SHALL have parameter: C_FRAME_WORDS, 256, words per frame (range 2..65535).
REQ-002 SHALL have port: i_aclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port: i_reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_enable  input  1  receive enable (0 = IDLE).
REQ-005 SHALL have port: i_encrypt_type  input  1  0 = PRBS keystream, 1 = ChaCha20 keystream.
REQ-006 SHALL have port: i_key_reload  input  1  single-cycle pulse forcing resynchronisation.
REQ-007 SHALL have port: s_axis_tvalid  input  1  ciphertext word valid.
REQ-008 SHALL have port: s_axis_tready  output  1  ciphertext word accepted.
REQ-009 SHALL have port: s_axis_sof  input  1  first word of frame.
REQ-010 SHALL have port: s_axis_tdata  input  32  ciphertext word.
REQ-011 SHALL have port: m_axis_tvalid  output  1  plaintext word valid.
REQ-012 SHALL have port: m_axis_tready  input  1  downstream ready.
REQ-013 SHALL have port: m_axis_sof  output  1  first plaintext word of frame.
REQ-014 SHALL have port: m_axis_tdata  output  32  plaintext word.
REQ-015 SHALL have port: i_prbs_data  input  32  current PRBS keystream word, always valid.
REQ-016 SHALL have port: o_prbs_run  output  1  advance PRBS generator one word.
REQ-017 SHALL have port: i_keystream_data  input  32  ChaCha20 keystream word.
REQ-018 SHALL have port: i_keystream_valid  input  1  ChaCha20 keystream word available.
REQ-019 SHALL have port: o_keystream_ready  output  1  consume ChaCha20 keystream word.
REQ-020 SHALL have port: o_state  output  2  FSM state: 0 IDLE, 1 WAIT_SOF, 2 RUN.
REQ-021 SHALL have port: o_sof_error  output  1  sticky framing error.
REQ-022 SHALL have port: o_frame_count  output  16  frames started, wraps 0xFFFF->0.
REQ-023 SHALL have port: o_drop_count  output  16  words dropped, saturates at 0xFFFF.

Function
REQ-024 SHALL define: ks_ok = i_encrypt_type ? i_keystream_valid : 1; out_free = !m_axis_tvalid || m_axis_tready; fire = s_axis_tvalid && s_axis_tready.
REQ-025 SHALL drive s_axis_tready: IDLE 0; WAIT_SOF 1; RUN ks_ok && out_free.
REQ-026 SHALL transition IDLE->WAIT_SOF when i_enable=1; any state->IDLE next cycle when i_enable=0 (priority over all other transitions).
REQ-027 SHALL, in WAIT_SOF, drop every fired word with sof=0 (drop_count+1) and, on fired word with sof=1, go to RUN and process that word as frame word 0.
REQ-028 SHALL, on a processed word (RUN fire, or WAIT_SOF fire with sof=1 only if ks_ok && out_free; otherwise that word is not accepted), load m_axis_tdata = s_axis_tdata XOR selected keystream, m_axis_tvalid=1, m_axis_sof = (word index==0); latency exactly 1 cycle.
REQ-029 SHALL assert o_prbs_run (mode 0) or o_keystream_ready (mode 1) for exactly the cycles in which a word is processed; never for dropped words; opposite-mode strobe stays 0.
REQ-030 SHALL keep word index 0..C_FRAME_WORDS-1, wrapping to 0 after the last word; frame_count increments on every processed word with index 0.
REQ-031 SHALL, in RUN at index 0 with sof=0: set o_sof_error, drop word, go WAIT_SOF.
REQ-032 SHALL, in RUN at index !=0 with sof=1: set o_sof_error, process word as index 0 of a new frame.
REQ-033 SHALL, on i_key_reload=1 (with i_enable=1): go WAIT_SOF, clear index, no word accepted that cycle.
REQ-034 SHALL hold m_axis_tdata/m_axis_sof stable while m_axis_tvalid=1 and m_axis_tready=0; clear m_axis_tvalid when taken with no new word; a pending output word survives IDLE/reload and is delivered.
REQ-035 SHALL clear o_sof_error only on reset or i_key_reload.

Reset
REQ-036 SHALL on i_reset=1 set state IDLE, index 0, m_axis_tvalid 0, m_axis_sof 0, m_axis_tdata 0, o_sof_error 0, both counters 0; all strobes 0 during reset.

Verification
REQ-037 PRBS, C_FRAME_WORDS=4, i_prbs_data=0xA5A5A5A5, words 0x5A5A5A5A(sof),0x00000000,0xA5A5A5A5,0x12345678 -> out 0xFFFFFFFF(sof),0xA5A5A5A5,0x00000000,0xB791F3DD, one cycle after each fire, 4 o_prbs_run pulses, frame_count=1.
REQ-038 ChaCha20, i_keystream_valid=0 for 5 cycles with s_axis_tvalid=1 in RUN -> s_axis_tready=0, no strobe; valid=1 -> word accepted, o_keystream_ready one pulse.
REQ-039 3 sof=0 words then sof word in WAIT_SOF -> drop_count=3, first output has m_axis_sof=1, o_sof_error=0.
REQ-040 C_FRAME_WORDS=4, sof on word index 2 -> o_sof_error=1, that output m_axis_sof=1, frame_count=2; word at index 0 with sof=0 -> dropped, o_state=1.
REQ-041 m_axis_tready=0 for 10 cycles -> one output held stable, s_axis_tready=0; i_reset mid-frame -> all outputs at REQ-036 values next cycle.

Source files
------------

// File: rtl/rx_decrypt_if.sv
// Word stream bundle shared by the ciphertext input and the plaintext output
// of rx_decrypt.
//   tvalid : producer has a word
//   tready : consumer takes the word on a rising edge with tvalid=1
//   sof    : word is the first of a frame
//   tdata  : 32-bit payload
// master = producer side, slave = consumer side.
interface rx_decrypt_if;
    logic        tvalid;
    logic        tready;
    logic        sof;
    logic [31:0] tdata;

    modport master (output tvalid, output sof, output tdata, input tready);
    modport slave  (input tvalid, input sof, input tdata, output tready);
endinterface

// File: rtl/rx_decrypt.sv
// Receive-side stream decryptor. Ciphertext words are XORed with either a
// free-running PRBS word or a ChaCha20 keystream word and presented one cycle
// later on the output stream. The block tracks frame alignment using the
// sof flag, drops words that arrive outside a frame, and flags framing errors.
//
// Ports
//   i_aclk, i_reset      : clock, synchronous active-high reset
//   i_enable             : 0 forces IDLE
//   i_encrypt_type       : 0 = PRBS keystream, 1 = ChaCha20 keystream
//   i_key_reload         : pulse, resynchronise to the next sof word
//   s_axis (slave)       : ciphertext stream in
//   m_axis (master)      : plaintext stream out
//   i_prbs_data          : current PRBS word, o_prbs_run advances it
//   i_keystream_*        : ChaCha20 keystream word, o_keystream_ready consumes it
//   o_state              : 0 IDLE, 1 WAIT_SOF, 2 RUN
//   o_sof_error          : sticky framing error
//   o_frame_count        : frames started (wrapping)
//   o_drop_count         : words dropped (saturating)
//
// state    | meaning
// IDLE     | receiver disabled, no input accepted
// WAIT_SOF | hunting for a sof word, non-sof words are dropped
// RUN      | inside a frame, every accepted word is decrypted
module rx_decrypt #(
    parameter int unsigned C_FRAME_WORDS = 256
) (
    input  logic         i_aclk,
    input  logic         i_reset,
    input  logic         i_enable,
    input  logic         i_encrypt_type,
    input  logic         i_key_reload,
    rx_decrypt_if.slave  s_axis,
    rx_decrypt_if.master m_axis,
    input  logic [31:0]  i_prbs_data,
    output logic         o_prbs_run,
    input  logic [31:0]  i_keystream_data,
    input  logic         i_keystream_valid,
    output logic         o_keystream_ready,
    output logic [1:0]   o_state,
    output logic         o_sof_error,
    output logic [15:0]  o_frame_count,
    output logic [15:0]  o_drop_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(C_FRAME_WORDS - 1);

    state_t      state;
    logic [15:0] word_idx;
    logic        out_valid;
    logic        out_sof;
    logic [31:0] out_data;
    logic        sof_error;
    logic [15:0] frame_count;
    logic [15:0] drop_count;

    logic        ks_ok;
    logic        out_free;
    logic        in_ready;
    logic        fire;
    logic        idx_zero;
    logic        drop_word;
    logic        process_word;
    logic        sof_err_set;
    logic [31:0] ks_word;

    assign ks_ok    = i_encrypt_type ? i_keystream_valid : 1'b1;
    assign out_free = !out_valid || m_axis.tready;
    assign ks_word  = i_encrypt_type ? i_keystream_data : i_prbs_data;
    assign idx_zero = (word_idx == 16'd0);

    // A sof word in WAIT_SOF is only taken when it can be decrypted straight
    // away; non-sof words are always swallowed there so they can be counted.
    // Disable, reload and reset cycles take nothing.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            ST_WAIT_SOF: in_ready = !s_axis.sof || (ks_ok && out_free);
            ST_RUN:      in_ready = ks_ok && out_free;
            default:     in_ready = 1'b0;
        endcase
        if (!i_enable || i_key_reload || i_reset) begin
            in_ready = 1'b0;
        end
    end

    assign s_axis.tready = in_ready;
    assign fire          = s_axis.tvalid && in_ready;

    assign drop_word    = fire && !s_axis.sof &&
                          ((state == ST_WAIT_SOF) || (state == ST_RUN && idx_zero));
    assign process_word = fire && !drop_word;
    assign sof_err_set  = fire && (state == ST_RUN) && (idx_zero != s_axis.sof);

    assign o_prbs_run        = process_word && !i_encrypt_type;
    assign o_keystream_ready = process_word && i_encrypt_type;

    always_ff @(posedge i_aclk) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            word_idx    <= 16'd0;
            out_valid   <= 1'b0;
            out_sof     <= 1'b0;
            out_data    <= 32'd0;
            sof_error   <= 1'b0;
            frame_count <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            // Output register runs independently of the FSM so a pending word
            // still drains after disable or reload.
            if (process_word) begin
                out_data  <= s_axis.tdata ^ ks_word;
                out_valid <= 1'b1;
                out_sof   <= s_axis.sof;
            end else if (m_axis.tready) begin
                out_valid <= 1'b0;
            end

            // Every processed word carrying sof starts frame index 0.
            if (process_word && s_axis.sof) begin
                frame_count <= frame_count + 16'd1;
            end

            if (drop_word && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            if (i_key_reload) begin
                sof_error <= 1'b0;
            end else if (sof_err_set) begin
                sof_error <= 1'b1;
            end

            if (!i_enable) begin
                state    <= ST_IDLE;
                word_idx <= 16'd0;
            end else if (i_key_reload) begin
                state    <= ST_WAIT_SOF;
                word_idx <= 16'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state    <= ST_WAIT_SOF;
                        word_idx <= 16'd0;
                    end
                    ST_WAIT_SOF: begin
                        if (process_word) begin
                            state    <= ST_RUN;
                            word_idx <= 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (drop_word) begin
                            state    <= ST_WAIT_SOF;
                            word_idx <= 16'd0;
                        end else if (process_word) begin
                            if (s_axis.sof) begin
                                word_idx <= 16'd1;
                            end else if (word_idx == LAST_IDX) begin
                                word_idx <= 16'd0;
                            end else begin
                                word_idx <= word_idx + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        word_idx <= 16'd0;
                    end
                endcase
            end
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.sof    = out_sof;
    assign m_axis.tdata  = out_data;
    assign o_state       = state;
    assign o_sof_error   = sof_error;
    assign o_frame_count = frame_count;
    assign o_drop_count  = drop_count;

endmodule
